// File: rtl/iir_pkg.sv
// Shared constants, types and state encoding for the iir / inverse-FIR datapaths.
package iir_pkg;

    localparam int unsigned DATA_W    = 15;
    localparam int unsigned COEF_W    = 16;
    localparam int unsigned FRAC_BITS = 14;
    localparam int unsigned ACC_W     = 33;
    localparam int unsigned PROD_W    = DATA_W + COEF_W;
    localparam int unsigned ADDR_W    = 2;

    typedef logic signed [DATA_W-1:0] sample_t;
    typedef logic signed [COEF_W-1:0] coef_t;
    typedef logic signed [ACC_W-1:0]  acc_t;
    typedef logic signed [PROD_W-1:0] prod_t;

    localparam sample_t DATA_MAX = DATA_W'(16383);
    localparam sample_t DATA_MIN = DATA_W'(-16384);
    localparam coef_t   COEF_ONE = COEF_W'(16'h4000);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MAC0 = 3'd1,
        MAC1 = 3'd2,
        MAC2 = 3'd3,
        OUT  = 3'd4
    } state_t;

endpackage

// File: rtl/iir_inverse_fir_if.sv
// Sample-in / sample-out handshakes plus the coefficient write port.
interface iir_inverse_fir_if;
    import iir_pkg::*;

    sample_t            in_data;
    logic               in_valid;
    logic               in_ready;
    sample_t            out_data;
    logic               out_valid;
    logic               out_ready;
    logic               coef_we;
    logic [ADDR_W-1:0]  coef_addr;
    coef_t              coef_data;

    modport master (
        output in_data, in_valid, out_ready, coef_we, coef_addr, coef_data,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready, coef_we, coef_addr, coef_data,
        output in_ready, out_data, out_valid
    );

endinterface

// File: rtl/iir_round_sat.sv
// Round-half-up of a Q.FRAC_BITS accumulator to an integer sample, then clamp to sample range.
module iir_round_sat
    import iir_pkg::*;
(
    input  acc_t    acc,
    output sample_t dout
);

    localparam int unsigned SHR_W = ACC_W - FRAC_BITS;
    localparam acc_t HALF = ACC_W'(2 ** (FRAC_BITS - 1));
    localparam logic signed [SHR_W-1:0] HI = SHR_W'(DATA_MAX);
    localparam logic signed [SHR_W-1:0] LO = SHR_W'(DATA_MIN);

    acc_t                     biased;
    logic signed [SHR_W-1:0]  shifted;

    // Accumulator headroom guarantees the bias add cannot wrap.
    always_comb begin
        biased  = acc + HALF;
        shifted = SHR_W'(biased >>> FRAC_BITS);
        if (shifted > HI) begin
            dout = DATA_MAX;
        end else if (shifted < LO) begin
            dout = DATA_MIN;
        end else begin
            dout = DATA_W'(shifted);
        end
    end

endmodule

// File: rtl/iir_inverse_fir.sv
// 3-tap inverse FIR for the iir block, one shared MAC stepped by a five-state sequencer.
module iir_inverse_fir
    import iir_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    iir_inverse_fir_if.slave  bus
);

    state_t  state;
    state_t  state_nxt;

    sample_t d0, d1, d2;
    coef_t   c0, c1, c2;
    acc_t    acc;

    sample_t out_data_q;
    logic    out_valid_q;
    logic    in_ready_q;

    logic    accept_c;
    logic    coef_wr_c;
    coef_t   coef_sel_c;
    sample_t data_sel_c;
    prod_t   prod_c;
    acc_t    acc_sum_c;
    sample_t result_c;

    assign accept_c  = (state == IDLE) && bus.in_valid;
    assign coef_wr_c = (state == IDLE) && bus.coef_we;

    // Tap select for the shared multiplier.
    always_comb begin
        coef_sel_c = '0;
        data_sel_c = '0;
        case (state)
            MAC0: begin coef_sel_c = c0; data_sel_c = d0; end
            MAC1: begin coef_sel_c = c1; data_sel_c = d1; end
            MAC2: begin coef_sel_c = c2; data_sel_c = d2; end
            default: ;
        endcase
    end

    assign prod_c    = PROD_W'(coef_sel_c) * PROD_W'(data_sel_c);
    assign acc_sum_c = acc + ACC_W'(prod_c);

    iir_round_sat u_round_sat (
        .acc  (acc_sum_c),
        .dout (result_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid) state_nxt = MAC0;
            MAC0:    state_nxt = MAC1;
            MAC1:    state_nxt = MAC2;
            MAC2:    state_nxt = OUT;
            OUT:     if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // History, coefficients, accumulator and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            d0          <= '0;
            d1          <= '0;
            d2          <= '0;
            c0          <= COEF_ONE;
            c1          <= '0;
            c2          <= '0;
            acc         <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            if (coef_wr_c) begin
                case (bus.coef_addr)
                    2'd0:    c0 <= bus.coef_data;
                    2'd1:    c1 <= bus.coef_data;
                    2'd2:    c2 <= bus.coef_data;
                    default: ;
                endcase
            end
            if (accept_c) begin
                d2  <= d1;
                d1  <= d0;
                d0  <= bus.in_data;
                acc <= '0;
            end else if (state inside {MAC0, MAC1, MAC2}) begin
                acc <= acc_sum_c;
            end
            if (state == MAC2) begin
                out_data_q <= result_c;
            end
            in_ready_q  <= (state_nxt == IDLE);
            out_valid_q <= (state_nxt == OUT);
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.in_ready  = in_ready_q;

endmodule

// File: tb/tb_iir_inverse_fir.sv
// Directed bench for iir_inverse_fir with a cycle-level reference model of the filter.
module tb_iir_inverse_fir;
    import iir_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    iir_inverse_fir_if bus ();

    iir_inverse_fir dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    int got[$];

    // Reference model: taps, history, and progress of the sample in flight.
    int mc[3];
    int mh[3];
    bit busy    = 1'b0;
    int cnt     = 0;
    int exp_out = 0;
    bit armed   = 1'b0;

    localparam int OUT_AFTER = 3;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    function automatic int ref_out(input int a0, input int a1, input int a2,
                                   input int h0, input int h1, input int h2);
        longint s;
        s = longint'(a0) * h0 + longint'(a1) * h1 + longint'(a2) * h2;
        s = (s + 8192) >>> 14;
        if (s > 16383)  s = 16383;
        if (s < -16384) s = -16384;
        return int'(s);
    endfunction

    // Per-cycle comparison, then advance the model to the next edge.
    always @(negedge clk) begin
        if (armed) begin
            chk("in_ready", int'(bus.in_ready), int'(!busy));
            chk("out_valid", int'(bus.out_valid), int'(busy && cnt >= OUT_AFTER));
            if (busy && cnt >= OUT_AFTER)
                chk("out_data", int'(bus.out_data), exp_out);
            if (bus.out_valid && bus.out_ready)
                got.push_back(int'(bus.out_data));
        end
        if (rst) begin
            mc[0] = 16384; mc[1] = 0; mc[2] = 0;
            mh[0] = 0;     mh[1] = 0; mh[2] = 0;
            busy  = 1'b0;
            cnt   = 0;
            armed = 1'b1;
        end else if (!busy) begin
            if (bus.coef_we && bus.coef_addr != 2'd3)
                mc[bus.coef_addr] = int'(bus.coef_data);
            if (bus.in_valid) begin
                mh[2]   = mh[1];
                mh[1]   = mh[0];
                mh[0]   = int'(bus.in_data);
                exp_out = ref_out(mc[0], mc[1], mc[2], mh[0], mh[1], mh[2]);
                busy    = 1'b1;
                cnt     = 0;
            end
        end else begin
            if (cnt >= OUT_AFTER && bus.out_ready) busy = 1'b0;
            else cnt++;
        end
    end

    task automatic wait_idle(input string name);
        int n = 0;
        while (!bus.in_ready) begin
            @(posedge clk); #1;
            n++;
            if (n > 200) begin
                timeout_fail(name);
                return;
            end
        end
    endtask

    task automatic send(input int v);
        wait_idle("send_wait");
        bus.in_data  = DATA_W'(v);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic write_coef(input int addr, input int val);
        wait_idle("write_wait");
        bus.coef_we   = 1'b1;
        bus.coef_addr = 2'(addr);
        bus.coef_data = COEF_W'(val);
        @(posedge clk); #1;
        bus.coef_we   = 1'b0;
    endtask

    task automatic wait_got(input int n);
        int k = 0;
        while (got.size() < n) begin
            @(posedge clk); #1;
            k++;
            if (k > 500) begin
                timeout_fail("wait_outputs");
                return;
            end
        end
    endtask

    task automatic chk_got(input string name, input int idx, input int req);
        if (idx < got.size()) chk(name, got[idx], req);
        else timeout_fail(name);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        got.delete();
    endtask

    initial begin
        int ident[6];
        int k;
        ident = '{1000, 4, 1, 5, 11, 233};
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.coef_we   = 1'b0;
        bus.coef_addr = '0;
        bus.coef_data = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        chk("reset_in_ready", int'(bus.in_ready), 1);
        chk("reset_out_valid", int'(bus.out_valid), 0);
        chk("reset_out_data", int'(bus.out_data), 0);

        // Identity filter straight out of reset.
        foreach (ident[i]) send(ident[i]);
        wait_got(6);
        foreach (ident[i]) chk_got("identity", i, ident[i]);

        // First-order inverse with c1 = -0.5.
        do_reset();
        write_coef(1, 16'hE000);
        send(1000);
        send(4);
        wait_got(2);
        chk_got("first_order_0", 0, 1000);
        chk_got("first_order_1", 1, -496);

        // Round-half-up with c0 = 0.5.
        do_reset();
        write_coef(0, 16'h2000);
        send(3);
        send(-3);
        send(1);
        wait_got(3);
        chk_got("round_0", 0, 2);
        chk_got("round_1", 1, -1);
        chk_got("round_2", 2, 1);

        // Saturation at both rails.
        do_reset();
        write_coef(0, 16'h7FFF);
        send(16383);
        send(-16384);
        wait_got(2);
        chk_got("sat_hi", 0, 16383);
        chk_got("sat_lo", 1, -16384);

        // Backpressure in OUT plus a dropped write during MAC1.
        do_reset();
        bus.out_ready = 1'b0;
        send(100);
        @(posedge clk); #1;
        bus.coef_we   = 1'b1;
        bus.coef_addr = 2'd0;
        bus.coef_data = COEF_W'(16'h2000);
        @(posedge clk); #1;
        bus.coef_we   = 1'b0;
        k = 0;
        while (!bus.out_valid && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        if (!bus.out_valid) timeout_fail("bp_out_valid");
        repeat (6) @(posedge clk);
        #1 bus.out_ready = 1'b1;
        send(50);
        wait_got(2);
        chk_got("bp_held", 0, 100);
        chk_got("bp_coef_kept", 1, 50);

        // Reset during MAC1 clears history, coefficients and the in-flight sample.
        do_reset();
        write_coef(1, 16'h4000);
        send(9);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_in_ready", int'(bus.in_ready), 1);
        chk("midrst_out_valid", int'(bus.out_valid), 0);
        send(7);
        wait_got(1);
        chk_got("midrst_sample", 0, 7);
        chk("midrst_count", got.size(), 1);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish at %0t", $time);
        $fatal(1, "global timeout");
    end

endmodule
